// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the FIR sample sequencer.
package fir_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitFir,
        StCapture
    } fir_seq_state_t;

    localparam int unsigned DEF_TIMEOUT = 64;

    // Watchdog width for a given TIMEOUT; never narrower than one bit.
    function automatic int unsigned wd_width(input int unsigned timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/fir_seq_fifo.sv
// Sample FIFO for the FIR sequencer. Pointers carry one extra wrap bit so that
// full and empty can be told apart when the address bits match.
module fir_seq_fifo #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
        end
    end

    // Storage is not reset; contents are only observable behind the pointers.
    always_ff @(posedge ck) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/fir_sequencer.sv
// Feeds buffered ADC samples one at a time to the FIR and presents each result on valid/ready.
// Define FIR_SEQ_TIMEOUT_EN to build the WAIT_FIR watchdog; otherwise timeout_err is tied low.
module fir_sequencer
    import fir_seq_pkg::*;
#(
    parameter int unsigned N       = 20,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic         ck,
    input  logic         rst,
    input  logic [N-1:0] s_data,
    input  logic         s_valid,
    output logic [N-1:0] fir_in,
    output logic         fir_input_ready,
    input  logic [N-1:0] fir_out,
    input  logic         fir_output_ready,
    output logic [N-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready,
    input  logic         clear_err,
    output logic         overflow,
    output logic         timeout_err,
    output logic         busy
);
    fir_seq_state_t state_q, state_d;

    logic [N-1:0] fifo_dout;
    logic         fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic         out_free, load_out, wd_expired;
    logic [N-1:0] fir_in_q, m_data_q;
    logic         m_valid_q, overflow_q, timeout_q;

    fir_seq_fifo #(
        .WIDTH(N),
        .DEPTH(DEPTH)
    ) u_fifo (
        .ck   (ck),
        .rst  (rst),
        .push (fifo_push),
        .pop  (fifo_pop),
        .din  (s_data),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_ff @(posedge ck or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // A finished capture with more work queued goes straight to ISSUE, keeping the
    // per-sample loop at N+4 cycles.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (!fifo_empty) state_d = StIssue;
            StIssue:   state_d = StWaitFir;
            StWaitFir: begin
                if (fir_output_ready) state_d = StCapture;
                else if (wd_expired)  state_d = StIdle;
            end
            StCapture: if (out_free) state_d = fifo_empty ? StIdle : StIssue;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        fir_input_ready = 1'b0;
        load_out        = 1'b0;
        fifo_pop        = 1'b0;
        unique case (state_q)
            StIdle:    fifo_pop = !fifo_empty;
            StIssue:   fir_input_ready = 1'b1;
            StCapture: begin
                load_out = out_free;
                fifo_pop = out_free && !fifo_empty;
            end
            default: ;
        endcase
    end

    assign out_free  = !m_valid_q || m_ready;
    assign fifo_push = s_valid && (!fifo_full || fifo_pop);
    assign busy      = (state_q != StIdle) || !fifo_empty;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            fir_in_q   <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (fifo_pop) fir_in_q <= fifo_dout;
            if (load_out) m_data_q <= fir_out;
            m_valid_q  <= load_out || (m_valid_q && !m_ready);
            overflow_q <= (s_valid && !fifo_push) || (overflow_q && !clear_err);
        end
    end

`ifdef FIR_SEQ_TIMEOUT_EN
    localparam int unsigned WdW = wd_width(TIMEOUT);

    logic [WdW-1:0] wd_q;
    logic           timeout_set;

    always_ff @(posedge ck or posedge rst) begin
        if (rst)                      wd_q <= '0;
        else if (state_q == StIssue)  wd_q <= '0;
        else if (state_q == StWaitFir) wd_q <= wd_q + WdW'(1);
    end

    assign wd_expired  = (wd_q == WdW'(TIMEOUT - 1));
    // fir_output_ready takes priority over a watchdog expiring in the same cycle.
    assign timeout_set = (state_q == StWaitFir) && !fir_output_ready && wd_expired;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) timeout_q <= 1'b0;
        else     timeout_q <= timeout_set || (timeout_q && !clear_err);
    end
`else
    assign wd_expired = 1'b0;
    assign timeout_q  = 1'b0;
`endif

    assign fir_in      = fir_in_q;
    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_fir_sequencer.sv
// Scoreboard bench for fir_sequencer with a behavioural FIR (result = sample/2, fixed latency).
module tb_fir_sequencer;
    localparam int N       = 20;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic         ck;
    logic         rst;
    logic [N-1:0] s_data;
    logic         s_valid;
    logic [N-1:0] fir_in;
    logic         fir_input_ready;
    logic [N-1:0] fir_out;
    logic         fir_output_ready;
    logic [N-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         clear_err;
    logic         overflow;
    logic         timeout_err;
    logic         busy;

    fir_sequencer #(
        .N      (N),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .ck              (ck),
        .rst             (rst),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .fir_in          (fir_in),
        .fir_input_ready (fir_input_ready),
        .fir_out         (fir_out),
        .fir_output_ready(fir_output_ready),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .clear_err       (clear_err),
        .overflow        (overflow),
        .timeout_err     (timeout_err),
        .busy            (busy)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    int cyc = 0;
    always @(posedge ck) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural FIR: loads fir_in one cycle after the issue pulse, raises
    // fir_output_ready fir_lat cycles after the pulse, result valid the cycle after.
    int           fir_lat = N + 2;
    int           fir_cnt = 0;
    bit           fir_run = 1'b0;
    logic [N-1:0] fir_acc;

    always @(posedge ck or posedge rst) begin
        if (rst) begin
            fir_run          <= 1'b0;
            fir_cnt          <= 0;
            fir_output_ready <= 1'b0;
            fir_out          <= '0;
            fir_acc          <= '0;
        end else begin
            fir_output_ready <= 1'b0;
            if (fir_input_ready) begin
                fir_run <= 1'b1;
                fir_cnt <= 1;
            end else if (fir_run) begin
                fir_cnt <= fir_cnt + 1;
                if (fir_cnt == 1) fir_acc <= $signed(fir_in) >>> 1;
                if (fir_cnt == fir_lat - 1) fir_output_ready <= 1'b1;
                if (fir_output_ready) begin
                    fir_out <= fir_acc;
                    fir_run <= 1'b0;
                end
            end
        end
    end

    int issue_cnt = 0;
    always @(posedge ck) if (!rst && fir_input_ready) issue_cnt <= issue_cnt + 1;

    // Scoreboard monitor.
    int exp_q[$];
    int out_cyc[$];
    int exp_val;
    always @(negedge ck) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got m_data=%0d, expected no output (cycle %0d)",
                         $signed(m_data), cyc);
            end else begin
                exp_val = exp_q.pop_front();
                check("m_data", longint'($signed(m_data)), exp_val);
            end
            out_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic settle();
        @(negedge ck);
    endtask

    task automatic drive(input int d);
        s_valid = 1'b1;
        s_data  = d[N-1:0];
    endtask

    task automatic wait_mvalid(input int max, output int c);
        int n = 0;
        @(negedge ck);
        while (!m_valid && n < max) begin
            @(negedge ck);
            n++;
        end
        c = m_valid ? cyc : -1;
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        @(negedge ck);
        while ((busy || m_valid) && n < max) begin
            @(negedge ck);
            n++;
        end
        check(name, longint'(busy || m_valid), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fir_in"}, fir_in, 0);
        check({tag, "_fir_input_ready"}, fir_input_ready, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    int burst_in[6]  = '{400, -800, 1200, 64, -64, 9000};
    int burst_exp[5] = '{200, -400, 600, 32, -32};

    initial begin
        int t;
        int c;
        int base;
        int vcount;

        rst       = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        m_ready   = 1'b1;
        clear_err = 1'b0;
        repeat (3) @(posedge ck);
        settle();
        check_all_zero("reset");
        step();
        rst = 1'b0;
        step();

        // Single sample: issue at t+2, result at t+N+6.
        drive(1000);
        exp_q.push_back(500);
        t = cyc;
        step();
        s_valid = 1'b0;
        settle();
        check("t1_issue_at_t1", fir_input_ready, 0);
        step();
        settle();
        check("t1_issue_at_t2", fir_input_ready, 1);
        check("t1_fir_in", longint'($signed(fir_in)), 1000);
        step();
        settle();
        check("t1_issue_at_t3", fir_input_ready, 0);
        wait_mvalid(60, c);
        check("t1_latency", c - t, N + 6);
        wait_idle("t1_idle", 50);

        // Six back-to-back strobes: five accepted, sixth dropped.
        out_cyc.delete();
        step();
        t = cyc;
        for (int i = 0; i < 6; i++) begin
            drive(burst_in[i]);
            if (i < 5) exp_q.push_back(burst_exp[i]);
            if (i == 5) begin
                settle();
                check("t2_overflow_before_drop", overflow, 0);
            end
            step();
        end
        s_valid = 1'b0;
        settle();
        check("t2_overflow_after_drop", overflow, 1);
        wait_idle("t2_idle", 400);
        check("t2_output_count", out_cyc.size(), 5);
        if (out_cyc.size() > 0) check("t2_first_latency", out_cyc[0] - t, N + 6);
        for (int i = 1; i < out_cyc.size(); i++) check("t2_spacing", out_cyc[i] - out_cyc[i-1], N + 4);
        step();
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        settle();
        check("t2_overflow_cleared", overflow, 0);

        // Downstream stall: first result held, second parked in CAPTURE.
        step();
        m_ready = 1'b0;
        base    = issue_cnt;
        drive(2000);
        exp_q.push_back(1000);
        t = cyc;
        step();
        drive(-4000);
        exp_q.push_back(-2000);
        step();
        s_valid = 1'b0;
        wait_mvalid(60, c);
        check("t3_latency", c - t, N + 6);
        repeat (100) @(negedge ck);
        check("t3_m_valid_held", m_valid, 1);
        check("t3_m_data_held", longint'($signed(m_data)), 1000);
        check("t3_busy_in_capture", busy, 1);
        check("t3_issue_count", issue_cnt - base, 2);
        step();
        m_ready = 1'b1;
        wait_idle("t3_idle", 50);

`ifdef FIR_SEQ_TIMEOUT_EN
        // FIR never answers: flag set on the edge closing the TIMEOUT-th WAIT_FIR cycle.
        fir_lat = 100000;
        step();
        drive(3000);
        t = cyc;
        step();
        s_valid = 1'b0;
        step();
        drive(6000);
        exp_q.push_back(3000);
        step();
        s_valid = 1'b0;
        while (cyc < t + 2 + TIMEOUT) step();
        settle();
        check("t4_timeout_not_yet", timeout_err, 0);
        step();
        fir_lat = N + 2;
        settle();
        check("t4_timeout_set", timeout_err, 1);
        check("t4_idle_no_issue", fir_input_ready, 0);
        step();
        settle();
        check("t4_next_issue", fir_input_ready, 1);
        wait_idle("t4_idle", 60);
        step();
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        settle();
        check("t4_timeout_cleared", timeout_err, 0);

        // fir_output_ready exactly at watchdog expiry wins.
        fir_lat = TIMEOUT;
        step();
        drive(8000);
        exp_q.push_back(4000);
        step();
        s_valid = 1'b0;
        wait_idle("t5_idle", 200);
        check("t5_no_timeout", timeout_err, 0);
        fir_lat = N + 2;
`else
        // Without the watchdog a slow FIR is simply waited for.
        fir_lat = TIMEOUT + 20;
        step();
        drive(8000);
        exp_q.push_back(4000);
        step();
        s_valid = 1'b0;
        wait_idle("t5_idle", 300);
        check("t5_no_timeout", timeout_err, 0);
        fir_lat = N + 2;
`endif

        // Reset during WAIT_FIR with three samples queued.
        step();
        t = cyc;
        for (int i = 0; i < 4; i++) begin
            drive(100 * (i + 1));
            step();
        end
        s_valid = 1'b0;
        while (cyc < t + 10) step();
        rst = 1'b1;
        #1;
        check_all_zero("t6_async_reset");
        step();
        step();
        rst    = 1'b0;
        vcount = 0;
        repeat (60) begin
            @(negedge ck);
            if (m_valid) vcount++;
        end
        check("t6_no_output_after_reset", vcount, 0);
        check("t6_not_busy", busy, 0);
        step();
        drive(-500);
        exp_q.push_back(-250);
        step();
        s_valid = 1'b0;
        wait_idle("t6_recover_idle", 60);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, expected finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
